dmem_access_unit: RTL and testbench

- Initiator side of the data-memory port: the MEM-stage load/store unit that drives address, write_data, memWrite and memRead into the data memory, and samples read_data.
- Accepts one load/store request at a time from the pipeline via a valid/ready handshake.
- Holds memory strobes for a fixed, parameterised access time, then returns a one-cycle response (load data or store acknowledge).

---
 rtl/dmem_pkg.sv | 18 +
 rtl/dmem_access_unit_counter.sv | 26 ++
 rtl/dmem_access_unit.sv | 113 +++++++++++
 tb/tb_dmem_access_unit.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory access unit.
package dmem_pkg;

  localparam int ADDR_W_DEF  = 16;
  localparam int DATA_W_DEF  = 16;
  localparam int WORD_STRIDE = 2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  function automatic logic is_word_aligned(input logic [ADDR_W_DEF-1:0] addr);
    return (addr % WORD_STRIDE) == 0;
  endfunction

endpackage

// File: rtl/dmem_access_unit_counter.sv
// Access-time counter: counts strobe cycles and flags the last one.
module dmem_latency_counter #(
  parameter int MAX_COUNT = 1,
  parameter int CNT_W     = $clog2(MAX_COUNT + 1)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic inc,
  output logic terminal
);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk) begin
    if (!rst_n)
      count <= '0;
    else if (clear)
      count <= '0;
    else if (inc)
      count <= count + CNT_W'(1);
  end

  assign terminal = (count == CNT_W'(MAX_COUNT - 1));

endmodule

// File: rtl/dmem_access_unit.sv
// MEM-stage load/store initiator: one request at a time, fixed access time.
// Optional misalignment trap enabled by defining DMEM_ALIGN_CHECK_EN.
module dmem_access_unit
  import dmem_pkg::*;
#(
  parameter int ADDR_W      = ADDR_W_DEF,
  parameter int DATA_W      = DATA_W_DEF,
  parameter int MEM_LATENCY = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err,
  output logic              busy,
  output logic [ADDR_W-1:0] address,
  output logic [DATA_W-1:0] write_data,
  output logic              memWrite,
  output logic              memRead,
  input  logic [DATA_W-1:0] read_data
);

  state_t state;
  logic   accept;
  logic   cnt_last;

  assign accept = req_valid & req_ready;
  assign busy   = (state != IDLE);

  dmem_latency_counter #(.MAX_COUNT(MEM_LATENCY)) u_counter (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (state != ACCESS),
    .inc      (state == ACCESS),
    .terminal (cnt_last)
  );

`ifdef DMEM_ALIGN_CHECK_EN
  logic resp_err_q;
  assign resp_err = resp_err_q;
`else
  assign resp_err = 1'b0;
`endif

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      req_ready  <= 1'b0;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      address    <= '0;
      write_data <= '0;
      memWrite   <= 1'b0;
      memRead    <= 1'b0;
`ifdef DMEM_ALIGN_CHECK_EN
      resp_err_q <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          req_ready  <= 1'b1;
          resp_valid <= 1'b0;
          if (accept) begin
            req_ready <= 1'b0;
`ifdef DMEM_ALIGN_CHECK_EN
            // Odd addresses never reach memory; answer straight away.
            if (req_addr[0]) begin
              state      <= RESP;
              resp_valid <= 1'b1;
              resp_err_q <= 1'b1;
            end else
`endif
            begin
              state      <= ACCESS;
              address    <= req_addr;
              write_data <= req_wdata;
              memWrite   <= req_write;
              memRead    <= ~req_write;
            end
          end
        end
        ACCESS: begin
          if (cnt_last) begin
            memWrite   <= 1'b0;
            memRead    <= 1'b0;
            resp_valid <= 1'b1;
            // memWrite still holds the request type on this last cycle.
            if (!memWrite)
              resp_rdata <= read_data;
            state <= RESP;
          end
        end
        RESP: begin
          resp_valid <= 1'b0;
          req_ready  <= 1'b1;
          state      <= IDLE;
`ifdef DMEM_ALIGN_CHECK_EN
          resp_err_q <= 1'b0;
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_access_unit.sv
// Directed bench: instance 0 has MEM_LATENCY=1, instance 1 has MEM_LATENCY=3.
module tb_dmem_access_unit;
  import dmem_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]  rst_n, req_valid, req_write;
  logic [15:0] req_addr [2];
  logic [15:0] req_wdata [2];
  wire  [1:0]  req_ready, resp_valid, resp_err, busy, mem_write, mem_read;
  wire  [15:0] resp_rdata [2];
  wire  [15:0] address [2];
  wire  [15:0] write_data [2];
  wire  [15:0] read_data [2];
  logic [15:0] mem [2][256];

  int vectors = 0;
  int miscompares = 0;

  dmem_access_unit #(.MEM_LATENCY(1)) u_lat1 (
    .clk(clk), .rst_n(rst_n[0]), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_write(req_write[0]), .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
    .resp_valid(resp_valid[0]), .resp_rdata(resp_rdata[0]), .resp_err(resp_err[0]),
    .busy(busy[0]), .address(address[0]), .write_data(write_data[0]),
    .memWrite(mem_write[0]), .memRead(mem_read[0]), .read_data(read_data[0])
  );

  dmem_access_unit #(.MEM_LATENCY(3)) u_lat3 (
    .clk(clk), .rst_n(rst_n[1]), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_write(req_write[1]), .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
    .resp_valid(resp_valid[1]), .resp_rdata(resp_rdata[1]), .resp_err(resp_err[1]),
    .busy(busy[1]), .address(address[1]), .write_data(write_data[1]),
    .memWrite(mem_write[1]), .memRead(mem_read[1]), .read_data(read_data[1])
  );

  // Word-addressed memory models with asynchronous read, bit 0 ignored.
  assign read_data[0] = mem[0][address[0][8:1]];
  assign read_data[1] = mem[1][address[1][8:1]];
  always @(posedge clk) begin
    if (mem_write[0]) mem[0][address[0][8:1]] <= write_data[0];
    if (mem_write[1]) mem[1][address[1][8:1]] <= write_data[1];
  end

  // Issues one request on instance u and records what the DUT did with it.
  task automatic do_req(input int u, input logic wr, input logic [15:0] addr, input logic [15:0] wdata,
                        output logic [15:0] rdata, output logic err, output int lat,
                        output int rd_cyc, output int wr_cyc, output logic [15:0] addr_seen,
                        output logic [15:0] wdata_seen, output logic stable);
    int guard;
    guard = 0; rdata = '0; err = 1'b0; rd_cyc = 0; wr_cyc = 0;
    addr_seen = '0; wdata_seen = '0; stable = 1'b1;
    @(negedge clk);
    while (!req_ready[u] && guard < 50) begin @(negedge clk); guard++; end
    if (guard >= 50) begin
      $display("FAIL req_ready_timeout: unit %0d req_ready=%b required 1", u, req_ready[u]);
      vectors++; miscompares++;
    end
    req_valid[u] = 1'b1; req_write[u] = wr; req_addr[u] = addr; req_wdata[u] = wdata;
    for (lat = 1; lat <= 40; lat++) begin
      @(negedge clk);
      if (lat == 1) req_valid[u] = 1'b0;
      if (mem_read[u] || mem_write[u]) begin
        if (rd_cyc + wr_cyc == 0) begin
          addr_seen = address[u]; wdata_seen = write_data[u];
        end else if (address[u] !== addr_seen || write_data[u] !== wdata_seen) stable = 1'b0;
        if (mem_read[u] && mem_write[u]) stable = 1'b0;
        rd_cyc += int'(mem_read[u]);
        wr_cyc += int'(mem_write[u]);
      end
      if (resp_valid[u]) break;
    end
    if (lat > 40) begin
      $display("FAIL resp_timeout: unit %0d resp_valid=%b required 1 within 40 cycles", u, resp_valid[u]);
      vectors++; miscompares++;
    end
    rdata = resp_rdata[u];
    err = resp_err[u];
  endtask

  task automatic test_reset();
    rst_n = 2'b00; req_valid = 2'b00; req_write = 2'b00;
    req_addr[0] = '0; req_addr[1] = '0; req_wdata[0] = '0; req_wdata[1] = '0;
    repeat (3) @(negedge clk);
    for (int u = 0; u < 2; u++) begin
      vectors++;
      if ({req_ready[u], resp_valid[u], resp_err[u], busy[u], mem_write[u], mem_read[u],
           address[u], write_data[u], resp_rdata[u]} !== 54'd0) begin
        $display("FAIL reset_outputs: unit %0d ready=%b rv=%b err=%b busy=%b mw=%b mr=%b addr=%h wd=%h rd=%h required all 0",
                 u, req_ready[u], resp_valid[u], resp_err[u], busy[u], mem_write[u], mem_read[u],
                 address[u], write_data[u], resp_rdata[u]);
        miscompares++;
      end
    end
    rst_n = 2'b11;
    @(negedge clk);
    for (int u = 0; u < 2; u++) begin
      vectors++;
      if (req_ready[u] !== 1'b1 || busy[u] !== 1'b0) begin
        $display("FAIL post_reset_idle: unit %0d ready=%b busy=%b required 1/0", u, req_ready[u], busy[u]);
        miscompares++;
      end
    end
  endtask

  task automatic test_store_load_lat1();
    logic [15:0] rdata, a_s, w_s; logic err, st; int lat, rc, wc;
    do_req(0, 1'b1, 16'h0004, 16'hBEEF, rdata, err, lat, rc, wc, a_s, w_s, st);
    vectors++;
    if (wc !== 1 || rc !== 0 || a_s !== 16'h0004 || w_s !== 16'hBEEF || !st) begin
      $display("FAIL l1_store_strobe: wr=%0d rd=%0d addr=%h wd=%h stable=%b required 1/0/0004/beef/1", wc, rc, a_s, w_s, st);
      miscompares++;
    end
    vectors++;
    if (lat !== 2 || err !== 1'b0) begin
      $display("FAIL l1_store_latency: lat=%0d err=%b required 2/0", lat, err);
      miscompares++;
    end
    do_req(0, 1'b0, 16'h0004, 16'h0000, rdata, err, lat, rc, wc, a_s, w_s, st);
    vectors++;
    if (rdata !== 16'hBEEF || lat !== 2 || rc !== 1 || wc !== 0) begin
      $display("FAIL l1_load: rdata=%h lat=%0d rd=%0d wr=%0d required beef/2/1/0", rdata, lat, rc, wc);
      miscompares++;
    end
  endtask

  task automatic test_sweep();
    logic [15:0] rdata, a_s, w_s, addr; logic err, st; int lat, rc, wc;
    for (int i = 0; i < 16; i++) begin
      addr = 16'(i * WORD_STRIDE);
      do_req(1, 1'b1, addr, addr, rdata, err, lat, rc, wc, a_s, w_s, st);
      vectors++;
      if (wc !== 3 || rc !== 0 || a_s !== addr || w_s !== addr || !st || lat !== 4) begin
        $display("FAIL sweep_store: addr=%h wr=%0d rd=%0d a=%h wd=%h stable=%b lat=%0d required 3/0/%h/%h/1/4",
                 addr, wc, rc, a_s, w_s, st, lat, addr, addr);
        miscompares++;
      end
    end
    for (int i = 0; i < 16; i++) begin
      addr = 16'(i * WORD_STRIDE);
      do_req(1, 1'b0, addr, 16'h0000, rdata, err, lat, rc, wc, a_s, w_s, st);
      vectors++;
      if (rdata !== addr || rc !== 3 || wc !== 0 || a_s !== addr || !st || lat !== 4) begin
        $display("FAIL sweep_load: addr=%h rdata=%h rd=%0d wr=%0d stable=%b lat=%0d required %h/3/0/1/4",
                 addr, rdata, rc, wc, st, lat, addr);
        miscompares++;
      end
    end
    // Top-of-range address passes through; a store leaves resp_rdata alone.
    do_req(1, 1'b1, 16'hFFFE, 16'hA5A5, rdata, err, lat, rc, wc, a_s, w_s, st);
    vectors++;
    if (a_s !== 16'hFFFE || rdata !== 16'h001E) begin
      $display("FAIL wrap_store: addr=%h rdata=%h required fffe/001e", a_s, rdata);
      miscompares++;
    end
    do_req(1, 1'b0, 16'hFFFE, 16'h0000, rdata, err, lat, rc, wc, a_s, w_s, st);
    vectors++;
    if (a_s !== 16'hFFFE || rdata !== 16'hA5A5) begin
      $display("FAIL wrap_load: addr=%h rdata=%h required fffe/a5a5", a_s, rdata);
      miscompares++;
    end
  endtask

  task automatic test_back_to_back();
    int accepts, pulses, last, spacing_bad, ready_busy, bad_data, guard;
    accepts = 0; pulses = 0; last = -1; spacing_bad = 0; ready_busy = 0; bad_data = 0; guard = 0;
    @(negedge clk);
    while (!req_ready[1] && guard < 50) begin @(negedge clk); guard++; end
    req_valid[1] = 1'b1; req_write[1] = 1'b0; req_addr[1] = 16'h0006;
    for (int c = 0; c < 25; c++) begin
      if (req_ready[1] && req_valid[1]) accepts++;
      @(negedge clk);
      if (accepts == 3) req_valid[1] = 1'b0;
      if (req_ready[1] && busy[1]) ready_busy++;
      if (resp_valid[1]) begin
        if (last >= 0 && c - last != 5) spacing_bad++;
        if (resp_rdata[1] !== 16'h0006) bad_data++;
        last = c; pulses++;
      end
    end
    req_valid[1] = 1'b0;
    vectors++;
    if (pulses !== 3 || spacing_bad !== 0) begin
      $display("FAIL b2b_pulses: pulses=%0d bad_spacing=%0d required 3/0", pulses, spacing_bad);
      miscompares++;
    end
    vectors++;
    if (ready_busy !== 0 || bad_data !== 0) begin
      $display("FAIL b2b_ready_data: ready_while_busy=%0d bad_data=%0d required 0/0", ready_busy, bad_data);
      miscompares++;
    end
  endtask

  task automatic test_reset_mid_access();
    logic [15:0] rdata, a_s, w_s; logic err, st; int lat, rc, wc, stray, guard;
    stray = 0; guard = 0;
    @(negedge clk);
    while (!req_ready[1] && guard < 50) begin @(negedge clk); guard++; end
    req_valid[1] = 1'b1; req_write[1] = 1'b1; req_addr[1] = 16'h0040; req_wdata[1] = 16'h1234;
    @(negedge clk);
    req_valid[1] = 1'b0;
    vectors++;
    if (mem_write[1] !== 1'b1) begin
      $display("FAIL midrst_strobe_on: memWrite=%b required 1", mem_write[1]);
      miscompares++;
    end
    @(negedge clk);
    rst_n[1] = 1'b0;
    @(negedge clk);
    vectors++;
    if (mem_write[1] !== 1'b0 || busy[1] !== 1'b0 || resp_valid[1] !== 1'b0) begin
      $display("FAIL midrst_abort: memWrite=%b busy=%b resp_valid=%b required 0/0/0", mem_write[1], busy[1], resp_valid[1]);
      miscompares++;
    end
    rst_n[1] = 1'b1;
    repeat (6) begin @(negedge clk); if (resp_valid[1]) stray++; end
    vectors++;
    if (stray !== 0) begin
      $display("FAIL midrst_no_resp: stray resp_valid=%0d required 0", stray);
      miscompares++;
    end
    // The model wrote on both strobe edges before the reset took effect.
    do_req(1, 1'b0, 16'h0040, 16'h0000, rdata, err, lat, rc, wc, a_s, w_s, st);
    vectors++;
    if (rdata !== 16'h1234 || lat !== 4) begin
      $display("FAIL midrst_reload: rdata=%h lat=%0d required 1234/4", rdata, lat);
      miscompares++;
    end
  endtask

  task automatic test_align();
    logic [15:0] rdata, a_s, w_s; logic err, st; int lat, rc, wc;
    do_req(1, 1'b0, 16'h0003, 16'h0000, rdata, err, lat, rc, wc, a_s, w_s, st);
`ifdef DMEM_ALIGN_CHECK_EN
    vectors++;
    if (rc !== 0 || wc !== 0 || lat !== 1 || err !== 1'b1 || rdata !== 16'h1234) begin
      $display("FAIL align_trap: rd=%0d wr=%0d lat=%0d err=%b rdata=%h required 0/0/1/1/1234", rc, wc, lat, err, rdata);
      miscompares++;
    end
`else
    vectors++;
    if (rc !== 3 || wc !== 0 || a_s !== 16'h0003 || lat !== 4 || err !== 1'b0 || rdata !== 16'h0002) begin
      $display("FAIL align_pass: rd=%0d wr=%0d addr=%h lat=%0d err=%b rdata=%h required 3/0/0003/4/0/0002",
               rc, wc, a_s, lat, err, rdata);
      miscompares++;
    end
`endif
  endtask

  initial begin
    test_reset();
    test_store_load_lat1();
    test_sweep();
    test_back_to_back();
    test_reset_mid_access();
    test_align();
    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
